apb_sram_ctrl: RTL and testbench

//  APB3/APB4 slave fronting an inferred single-port synchronous SRAM; next-gen LSRAM/uSRAM APB wrapper.

---
 rtl/apb_sram_pkg.sv | 33 +++
 rtl/apb_sram_if.sv | 30 +++
 rtl/apb_sram_mem.sv | 46 ++++
 rtl/apb_sram_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_apb_sram_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/apb_sram_pkg.sv
// Shared types and helpers for the APB SRAM controller.
// Optional feature macro: APB_SRAM_PARITY_EN (per-byte even parity).
package apb_sram_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RD_PIPE,
        S_RESP
    } state_e;

`ifdef APB_SRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // One stored lane per byte: data plus optional parity bit.
    localparam int LANE_W = 8 + PAR_W;

    function automatic int addr_lsb(input int dwidth);
        return $clog2(dwidth / 8);
    endfunction

    function automatic int widx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/apb_sram_if.sv
// APB3/APB4 slave bus bundle for the SRAM controller,
// including the SII BUSY stall and the sticky parity flag.
interface apb_sram_if #(
    parameter int APB_DWIDTH  = 32,
    parameter int PADDR_WIDTH = 20
);
    localparam int NB = APB_DWIDTH / 8;

    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [PADDR_WIDTH-1:0] PADDR;
    logic [APB_DWIDTH-1:0]  PWDATA;
    logic [NB-1:0]          PSTRB;
    logic                   BUSY;
    logic [APB_DWIDTH-1:0]  PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;
    logic                   PARERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, BUSY,
        output PRDATA, PREADY, PSLVERR, PARERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, BUSY,
        input  PRDATA, PREADY, PSLVERR, PARERR
    );
endinterface

// File: rtl/apb_sram_mem.sv
// Byte-enabled single-port synchronous RAM with a
// RD_LATENCY-deep read pipeline. Contents are never reset.
module apb_sram_mem
    import apb_sram_pkg::*;
#(
    parameter int NB         = 4,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 1,
    parameter int WIDX_W     = 9
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic                          re,
    input  logic [WIDX_W-1:0]             addr,
    input  logic [NB-1:0]                 be,
    input  logic [NB-1:0][LANE_W-1:0]     wdata,
    output logic [NB-1:0][LANE_W-1:0]     rdata
);

    logic [NB-1:0][LANE_W-1:0] mem_q  [DEPTH];
    logic [NB-1:0][LANE_W-1:0] pipe_q [RD_LATENCY];

    // Byte-lane writes; disabled lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[addr][b] <= wdata[b];
                end
            end
        end
    end

    // Array read into stage 0, then a free-running shift pipeline.
    always_ff @(posedge clk) begin
        if (re) begin
            pipe_q[0] <= mem_q[addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/apb_sram_ctrl.sv
// APB slave fronting a sync SRAM: FSM, range check, read wait states.
// Optional feature macro: APB_SRAM_PARITY_EN (per-byte parity, PARERR).
module apb_sram_ctrl
    import apb_sram_pkg::*;
#(
    parameter int APB_DWIDTH  = 32,
    parameter int DEPTH       = 512,
    parameter int PADDR_WIDTH = 20,
    parameter int RD_LATENCY  = 1,
    parameter int USE_STRB    = 1
) (
    input  logic      PCLK,
    input  logic      PRESET,
    apb_sram_if.slave apb
);

    localparam int NB       = APB_DWIDTH / 8;
    localparam int ADDR_LSB = addr_lsb(APB_DWIDTH);
    localparam int WIDX_W   = widx_w(DEPTH);
    localparam logic [31:0] DEPTH_U  = DEPTH;
    localparam logic [1:0]  CNT_INIT = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    rd_q, rd_d;
    logic [APB_DWIDTH-1:0]   prdata_q, prdata_d;
    logic [PADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [APB_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    write_q, write_d;

    logic                    setup, oor, go, is_idle, in_rd_resp;
    logic                    mem_we, mem_re;
    logic                    cur_write;
    logic [PADDR_WIDTH-1:0]  cur_addr;
    logic [APB_DWIDTH-1:0]   cur_wdata;
    logic [NB-1:0]           cur_strb;
    logic [WIDX_W-1:0]       mem_addr;
    logic [NB-1:0]           mem_be;
    logic [NB-1:0][LANE_W-1:0] mem_wdata, mem_rdata;
    logic [APB_DWIDTH-1:0]   rd_data;

    assign setup      = apb.PSEL & ~apb.PENABLE;
    assign oor        = 32'(apb.PADDR >> ADDR_LSB) >= DEPTH_U;
    assign is_idle    = (state_q == S_IDLE);
    assign in_rd_resp = (state_q == S_RESP) && rd_q;

    // From IDLE the access uses the live bus; from HOLD the latched copy.
    assign cur_write = is_idle ? apb.PWRITE : write_q;
    assign cur_addr  = is_idle ? apb.PADDR  : addr_q;
    assign cur_wdata = is_idle ? apb.PWDATA : wdata_q;
    assign cur_strb  = is_idle ? apb.PSTRB  : strb_q;
    assign mem_addr  = WIDX_W'(cur_addr >> ADDR_LSB);
    assign mem_be    = (USE_STRB != 0) ? cur_strb : '1;

    // Pack write bytes into RAM lanes and unpack read lanes.
    always_comb begin
        mem_wdata = '0;
        rd_data   = '0;
        for (int b = 0; b < NB; b++) begin
`ifdef APB_SRAM_PARITY_EN
            mem_wdata[b] = {byte_par(cur_wdata[b*8 +: 8]), cur_wdata[b*8 +: 8]};
`else
            mem_wdata[b] = cur_wdata[b*8 +: 8];
`endif
            rd_data[b*8 +: 8] = mem_rdata[b][7:0];
        end
    end

    // Next-state, latency count, latched request and response regs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rd_d      = rd_q;
        prdata_d  = prdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        write_d   = write_q;
        go        = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    addr_d  = apb.PADDR;
                    wdata_d = apb.PWDATA;
                    strb_d  = apb.PSTRB;
                    write_d = apb.PWRITE;
                    if (oor) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        rd_d      = 1'b0;
                        prdata_d  = '0;
                    end else if (apb.BUSY) begin
                        state_d = S_HOLD;
                    end else begin
                        go = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!apb.BUSY) begin
                    go = 1'b1;
                end
            end
            S_RD_PIPE: begin
                if (cnt_q == 2'd0) begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (rd_q) begin
                    prdata_d = rd_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            if (cur_write) begin
                mem_we   = 1'b1;
                rd_d     = 1'b0;
                state_d  = S_RESP;
                pready_d = 1'b1;
            end else begin
                mem_re = 1'b1;
                rd_d   = 1'b1;
                if (RD_LATENCY > 1) begin
                    state_d = S_RD_PIPE;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                end
            end
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_q      <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rd_q      <= rd_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            write_q   <= write_d;
        end
    end

    apb_sram_mem #(
        .NB         (NB),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .WIDX_W     (WIDX_W)
    ) u_mem (
        .clk   (PCLK),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign apb.PREADY = pready_q;
    assign apb.PRDATA = in_rd_resp ? rd_data : prdata_q;

`ifdef APB_SRAM_PARITY_EN
    logic perr, resp_perr;
    logic parerr_q, parerr_d;

    // Any lane whose 9 stored bits have odd weight is corrupt.
    always_comb begin
        perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            perr = perr | (^mem_rdata[b]);
        end
    end

    assign resp_perr = in_rd_resp & perr;

    // Sticky parity error flag, cleared only by reset.
    always_comb begin
        parerr_d = parerr_q | resp_perr;
    end

    // Parity flag register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            parerr_q <= 1'b0;
        end else begin
            parerr_q <= parerr_d;
        end
    end

    assign apb.PSLVERR = pslverr_q | resp_perr;
    assign apb.PARERR  = parerr_q;
`else
    assign apb.PSLVERR = pslverr_q;
    assign apb.PARERR  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Directed bench for apb_sram_ctrl (32b, DEPTH=512, RD_LATENCY=3).
// Define APB_SRAM_PARITY_EN to also exercise parity corruption.
module tb_apb_sram_ctrl;

    localparam int RDL = 3;

    logic PCLK;
    logic PRESET;
    int   n_chk;
    int   n_pass;

    apb_sram_if #(.APB_DWIDTH(32), .PADDR_WIDTH(20)) bus ();

    apb_sram_ctrl #(
        .APB_DWIDTH  (32),
        .DEPTH       (512),
        .PADDR_WIDTH (20),
        .RD_LATENCY  (RDL),
        .USE_STRB    (1)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic setup_phase(input logic wr, input logic [19:0] addr,
                               input logic [31:0] wd, input logic [3:0] strb);
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        bus.PSTRB   = strb;
    endtask

    // Full transfer; address/data are scrambled in the access phase.
    task automatic xfer(input logic wr, input logic [19:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input logic busy_acc,
                        output logic [31:0] rd, output logic err,
                        output int waits);
        setup_phase(wr, addr, wd, strb);
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = addr ^ 20'h4;
        bus.PWDATA  = ~wd;
        bus.BUSY    = busy_acc;
        waits = 0;
        while (!bus.PREADY && waits < 20) begin
            @(posedge PCLK);
            #1;
            waits++;
        end
        rd  = bus.PRDATA;
        err = bus.PSLVERR;
        bus.BUSY = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          w;
    int          hi;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PSTRB   = '0;
        bus.BUSY    = 1'b0;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_pready", 32'(bus.PREADY), 32'd0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        check("rst_parerr", 32'(bus.PARERR), 32'd0);
        PRESET = 1'b0;

        xfer(1'b1, 20'h10, 32'h0, 4'hF, 1'b0, rd, err, w);
        check("wr_wait", 32'(w), 32'd0);
        xfer(1'b1, 20'h0, 32'hCAFEF00D, 4'hF, 1'b0, rd, err, w);
        xfer(1'b1, 20'h10, 32'hDEADBEEF, 4'h5, 1'b0, rd, err, w);
        check("strb_wr_err", 32'(err), 32'd0);
        check("strb_wr_wait", 32'(w), 32'd0);
        xfer(1'b0, 20'h10, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("strb_rd_data", rd, 32'h00AD00EF);
        check("strb_rd_err", 32'(err), 32'd0);
        check("rd_wait_b2b", 32'(w), 32'(RDL - 1));
        xfer(1'b0, 20'h12, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("unaligned_rd", rd, 32'h00AD00EF);
        xfer(1'b1, 20'h10, 32'h11111111, 4'h0, 1'b0, rd, err, w);
        check("strb0_err", 32'(err), 32'd0);
        xfer(1'b0, 20'h10, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("strb0_rd", rd, 32'h00AD00EF);

        xfer(1'b1, 20'h800, 32'h12345678, 4'hF, 1'b0, rd, err, w);
        check("oor_wr_wait", 32'(w), 32'd0);
        check("oor_wr_err", 32'(err), 32'd1);
        check("oor_wr_prdata", rd, 32'h0);
        xfer(1'b0, 20'h0, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("oor_no_alias", rd, 32'hCAFEF00D);
        xfer(1'b0, 20'h800, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("oor_rd_err", 32'(err), 32'd1);
        check("oor_rd_data", rd, 32'h0);
        xfer(1'b1, 20'h7FC, 32'h7FC07FC0, 4'hF, 1'b0, rd, err, w);
        check("top_wr_err", 32'(err), 32'd0);
        xfer(1'b0, 20'h7FC, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("top_rd_data", rd, 32'h7FC07FC0);
        check("top_rd_err", 32'(err), 32'd0);

        bus.BUSY = 1'b1;
        setup_phase(1'b1, 20'h30, 32'h30303030, 4'hF);
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.PREADY) hi++;
            @(posedge PCLK);
            #1;
        end
        check("busy_hold", 32'(hi), 32'd0);
        bus.BUSY = 1'b0;
        @(posedge PCLK);
        #1;
        check("busy_land", 32'(bus.PREADY), 32'd1);
        xfer(1'b0, 20'h30, 32'h0, 4'h0, 1'b1, rd, err, w);
        check("busy_rdpipe_data", rd, 32'h30303030);
        check("busy_rdpipe_wait", 32'(w), 32'(RDL - 1));

        setup_phase(1'b0, 20'h10, 32'h0, 4'h0);
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        check("midrst_pready", 32'(bus.PREADY), 32'd0);
        check("midrst_prdata", bus.PRDATA, 32'h0);
        PRESET = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        xfer(1'b0, 20'h30, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("midrst_keep", rd, 32'h30303030);

`ifdef APB_SRAM_PARITY_EN
        xfer(1'b1, 20'h20, 32'hA5A5A5A5, 4'hF, 1'b0, rd, err, w);
        dut.u_mem.mem_q[8][0][8] = ~dut.u_mem.mem_q[8][0][8];
        xfer(1'b0, 20'h20, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("par_err", 32'(err), 32'd1);
        check("par_data", rd, 32'hA5A5A5A5);
        @(posedge PCLK);
        #1;
        check("par_flag", 32'(bus.PARERR), 32'd1);
        xfer(1'b0, 20'h30, 32'h0, 4'h0, 1'b0, rd, err, w);
        check("par_clean_err", 32'(err), 32'd0);
        check("par_sticky", 32'(bus.PARERR), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("par_rst", 32'(bus.PARERR), 32'd0);
`endif

        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
